// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and
// grant identifiers used by the arbiter top and its winner-select logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef logic gnt_t;

    localparam gnt_t GNT_I = 1'b0;
    localparam gnt_t GNT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory port arbiter.
// Build option MEM_ARB_RR_EN: when defined, simultaneous requests are granted
// round-robin against the last grant; otherwise the D-port (older instruction)
// always wins over the I-port.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_vld,
    input  logic d_vld,
`ifdef MEM_ARB_RR_EN
    input  gnt_t last_gnt,
`endif
    output logic any_vld,
    output gnt_t gnt
);

    // Pick a winner among the currently valid requests.
    always_comb begin
        any_vld = i_vld | d_vld;
        gnt     = GNT_I;
`ifdef MEM_ARB_RR_EN
        if (i_vld && d_vld) begin
            gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (d_vld) begin
            gnt = GNT_D;
        end
`else
        if (d_vld) begin
            gnt = GNT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch port
// (read only) and the MEM-stage data port (read/write). Each transaction runs
// IDLE -> ISSUE (memory handshake) -> RESP (one-cycle ack to the winner).
// Build option MEM_ARB_RR_EN: round-robin grant on simultaneous requests with
// a last-grant register; undefined gives fixed D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_flush_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q;
    gnt_t              gnt_q;
    logic              cancel_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] rdata_q;
`ifdef MEM_ARB_RR_EN
    gnt_t              last_q;
`endif

    logic i_vld;
    logic d_vld;
    logic any_vld;
    gnt_t pick_gnt;

    // A fetch being flushed this cycle is not a candidate for the port.
    assign i_vld = i_req_i & ~i_flush_i;
    assign d_vld = d_req_i;

    mem_arb_pick u_pick (
        .i_vld    (i_vld),
        .d_vld    (d_vld),
`ifdef MEM_ARB_RR_EN
        .last_gnt (last_q),
`endif
        .any_vld  (any_vld),
        .gnt      (pick_gnt)
    );

    // The I ack is masked by a flush arriving in the RESP cycle itself, since
    // the registered ack was already committed on the previous edge.
    assign i_ack_o     = i_ack_q & ~i_flush_i;
    assign d_ack_o     = d_ack_q;
    assign i_rdata_o   = rdata_q;
    assign d_rdata_o   = rdata_q;
    assign if_stall_o  = i_req_i & ~i_ack_o & ~i_flush_i;
    assign mem_stall_o = d_req_i & ~d_ack_o;

    // Transaction FSM: latch the winner in IDLE, hold the memory request in
    // ISSUE until acked, then pulse the winner's ack from RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_I;
            cancel_q    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            rdata_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= GNT_I;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        state_q     <= ISSUE;
                        gnt_q       <= pick_gnt;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= (pick_gnt == GNT_D) & d_we_i;
                        mem_addr_o  <= (pick_gnt == GNT_D) ? d_addr_i : i_addr_i;
                        mem_wdata_o <= (pick_gnt == GNT_D) ? d_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
                        last_q      <= pick_gnt;
`endif
                    end
                end
                ISSUE: begin
                    if (gnt_q == GNT_I && i_flush_i) begin
                        cancel_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        state_q   <= RESP;
                        rdata_q   <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (gnt_q == GNT_D) begin
                            d_ack_q <= 1'b1;
                        end else begin
                            i_ack_q <= ~(cancel_q | i_flush_i);
                        end
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    cancel_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (I-port, read only) and the MEM-stage requester (D-port, read/write).
- Sequences each memory transaction over a req/ack handshake, returns read data, and drives pipeline stall lines so the PC/IF_ID and later stages hold while their access is outstanding.
- Sits between Instruction_Memory/data-memory users and the shared memory model.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
i_req_i  in  1  I-port request; held until i_ack_o
i_addr_i  in  ADDR_W  I-port byte address
i_flush_i  in  1  cancel pending/in-flight fetch (branch/jump taken)
i_ack_o  out  1  I-port completion pulse, 1 cycle
i_rdata_o  out  DATA_W  fetched word, valid when i_ack_o
d_req_i  in  1  D-port request; held until d_ack_o
d_we_i  in  1  D-port write enable
d_addr_i  in  ADDR_W  D-port address
d_wdata_i  in  DATA_W  D-port write data
d_ack_o  out  1  D-port completion pulse, 1 cycle
d_rdata_o  out  DATA_W  load data, valid when d_ack_o
if_stall_o  out  1  I-port request pending and not acked this cycle
mem_stall_o  out  1  D-port request pending and not acked this cycle
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion, 1-cycle pulse
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (rst_i=0 at an edge): state IDLE. All ack, stall, mem_req_o and mem_we_o outputs are 0. rdata and mem_addr/wdata registers are 0. Last-grant register = I.
- Reset mid-transaction: the arbiter abandons the transaction. mem_req_o is 0 in the first cycle after reset. No ack is issued.
- IDLE: if any valid request is present, pick a winner, latch addr/we/wdata/grant-id into registers, and go to ISSUE.
  - Default priority: D-port wins (older instruction).
  - A valid I request is i_req_i and not i_flush_i.
- ISSUE: mem_req_o=1 and mem_* driven from the latched registers (stable for the whole transaction). On mem_ack_i: capture mem_rdata_i and go to RESP.
- RESP: pulse the winner's ack for exactly 1 cycle with registered rdata, then go to IDLE. No arbitration in RESP.
- Minimum latency: request seen in IDLE at cycle 0, mem_req_o cycle 1, mem_ack_i cycle 1, ack_o cycle 2. Total = 2 + memory wait cycles.
- Requesters drop req on the edge after ack. A new request may be presented in the following cycle (IDLE).
- Flush:
  - i_flush_i in IDLE: the I request is ignored that cycle.
  - i_flush_i while an I transaction is in ISSUE or RESP: set a cancel flag. The memory transaction still completes, i_ack_o is suppressed, and the flag clears on return to IDLE.
  - Flush has no effect on D transactions.
- Stalls (combinational): if_stall_o = i_req_i & ~i_ack_o & ~i_flush_i. mem_stall_o = d_req_i & ~d_ack_o.
- Simultaneous i_req/d_req in IDLE: resolved by the priority rule. The loser stays stalled.
- Writes: RESP still pulses d_ack_o. d_rdata_o then holds the captured mem_rdata_i value, which is don't-care.
- The I-port never asserts mem_we_o.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests. The port not granted last wins. Last-grant updates on every grant. Bounds I-port starvation to one D transaction.
- Undefined: fixed D-over-I priority. The last-grant register is absent.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/ISSUE/RESP), grant-id constants (GNT_I=0, GNT_D=1).
- Sub-module mem_arb_pick: combinational winner select from valid requests, last-grant and the RR macro.

Test Plan:
- Single fetch: i_req with addr 0x0000_0010, memory acks after 3 wait cycles with 0x2002_0005 -> mem_req_o high cycles 1-4, i_ack_o=1 with i_rdata_o=0x2002_0005 at cycle 5, if_stall_o high cycles 0-4.
- Simultaneous requests: i_req (0x14) and d_req load (0x100) in the same cycle, fixed priority -> D served first, then I. With MEM_ARB_RR_EN and last grant=D -> I first.
- Store: d_req with we=1, addr 0x200, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_addr_o=0x200, mem_wdata_o=0xDEAD_BEEF stable until mem_ack_i; d_ack_o pulses once.
- Flush in flight: I transaction in ISSUE, i_flush_i pulsed -> memory completes, i_ack_o stays 0, next IDLE grants the new fetch.
- Reset mid-ISSUE: rst_i=0 for one edge while mem_req_o=1 -> next cycle mem_req_o=0, all acks 0, state IDLE, then a normal fetch completes.
- Back-to-back: D requests 5 consecutive loads while i_req is held, fixed priority -> I starved. With MEM_ARB_RR_EN -> grants alternate D, I, D.
